// File: rtl/spi_send_fifo_pkg.sv
// Shared peripheral definitions: AWrSize one-hot bit positions and the
// size-to-byte-count decode used by the IO blocks.
package spi_send_fifo_pkg;

  localparam int unsigned SizeB = 0;
  localparam int unsigned SizeW = 1;
  localparam int unsigned SizeD = 2;
  localparam int unsigned SizeQ = 3;

  // Highest set bit wins; an all-zero size means no write.
  function automatic logic [3:0] sizeToBytes(input logic [3:0] wrSize);
    logic [3:0] cnt;
    cnt = 4'd0;
    if (wrSize[SizeQ])      cnt = 4'd8;
    else if (wrSize[SizeD]) cnt = 4'd4;
    else if (wrSize[SizeW]) cnt = 4'd2;
    else if (wrSize[SizeB]) cnt = 4'd1;
    return cnt;
  endfunction

endpackage

// File: rtl/spi_send_fifo_if.sv
// Data-path bundle between the SPI codec side and the send FIFO.
interface spi_send_fifo_if;
  import spi_send_fifo_pkg::*;

  logic [63:0] ADataI;
  logic [3:0]  AWrSize;
  logic [7:0]  ADataO;
  logic        ARdEn;
  logic        AHasData;
  logic        AHasSpace;
  logic [15:0] AFreeSize;
  logic        AWrDrop;

  modport master (
    output ADataI, AWrSize, ARdEn,
    input  ADataO, AHasData, AHasSpace, AFreeSize, AWrDrop
  );

  modport slave (
    input  ADataI, AWrSize, ARdEn,
    output ADataO, AHasData, AHasSpace, AFreeSize, AWrDrop
  );

endinterface

// File: rtl/spi_fifo_lane_dec.sv
// Maps write address and byte count to per-slot write enables and the
// input byte lane each slot takes.
module spi_fifo_lane_dec
  import spi_send_fifo_pkg::*;
#(
  parameter int unsigned CAddrLen = 5,
  localparam int unsigned Depth = 1 << CAddrLen
) (
  input  logic [CAddrLen-1:0]    wrAddr,
  input  logic [3:0]             byteCnt,
  output logic [Depth-1:0]       slotWe,
  output logic [Depth-1:0][2:0]  slotLane
);

  logic [CAddrLen-1:0] offs;

  always_comb begin
    slotWe   = '0;
    slotLane = '0;
    offs     = '0;
    for (int s = 0; s < Depth; s++) begin
      // Offset of this slot from the write address, wrapping at the array end.
      offs        = CAddrLen'(s) - wrAddr;
      slotWe[s]   = 16'(offs) < 16'(byteCnt);
      slotLane[s] = offs[2:0];
    end
  end

endmodule

// File: rtl/spi_send_fifo.sv
// Byte-wide SPI send FIFO accepting 1/2/4/8-byte writes and single-byte
// show-ahead reads.
module spi_send_fifo
  import spi_send_fifo_pkg::*;
#(
  parameter int unsigned CAddrLen = 5
) (
  input  logic             AClkH,
  input  logic             AResetHN,
  input  logic             AClkHEn,
  input  logic             AScanI,
  output logic             AScanO,
  input  logic             AScanE,
  input  logic             AResetSN,
  spi_send_fifo_if.slave   bus
);

  localparam int unsigned Depth = 1 << CAddrLen;
  localparam int unsigned PtrW  = CAddrLen + 1;

  logic [PtrW-1:0] wrPtrQ, wrPtrD, rdPtrQ, rdPtrD;
  logic [PtrW-1:0] fill, free;
  logic            wrDropQ, wrDropD;
  logic [3:0]      byteCnt, wrCnt;
  logic            wrOk, rdOk;
  logic [7:0]      mem [Depth];

  logic [Depth-1:0]      slotWe;
  logic [Depth-1:0][2:0] slotLane;

  always_comb begin
    fill    = wrPtrQ - rdPtrQ;
    free    = PtrW'(Depth) - fill;
    byteCnt = sizeToBytes(bus.AWrSize);
    // Space is judged on the current free count; a same-cycle pop does not help.
    wrOk    = (byteCnt != 4'd0) && (16'(byteCnt) <= 16'(free));
    rdOk    = bus.ARdEn && (fill != '0);
    wrCnt   = wrOk ? byteCnt : 4'd0;
  end

  always_comb begin
    wrPtrD  = wrPtrQ;
    rdPtrD  = rdPtrQ;
    wrDropD = 1'b0;
    if (!AResetSN) begin
      wrPtrD = '0;
      rdPtrD = '0;
    end else begin
      wrPtrD  = wrPtrQ + PtrW'(wrCnt);
      rdPtrD  = rdPtrQ + PtrW'(rdOk);
      wrDropD = (byteCnt != 4'd0) && !wrOk;
    end
  end

  // Pointers and drop flag form the scan chain: AScanI -> wrPtr -> rdPtr -> drop.
  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      wrPtrQ  <= '0;
      rdPtrQ  <= '0;
      wrDropQ <= 1'b0;
    end else if (AScanE) begin
      {wrPtrQ, rdPtrQ, wrDropQ} <= {AScanI, wrPtrQ, rdPtrQ};
    end else if (AClkHEn) begin
      wrPtrQ  <= wrPtrD;
      rdPtrQ  <= rdPtrD;
      wrDropQ <= wrDropD;
    end
  end

  spi_fifo_lane_dec #(
    .CAddrLen (CAddrLen)
  ) u_lane_dec (
    .wrAddr   (wrPtrQ[CAddrLen-1:0]),
    .byteCnt  (wrCnt),
    .slotWe   (slotWe),
    .slotLane (slotLane)
  );

  always_ff @(posedge AClkH) begin
    if (AClkHEn && AResetSN && !AScanE) begin
      for (int s = 0; s < Depth; s++) begin
        if (slotWe[s]) mem[s] <= bus.ADataI[{slotLane[s], 3'b000} +: 8];
      end
    end
  end

  assign bus.ADataO    = mem[rdPtrQ[CAddrLen-1:0]];
  assign bus.AHasData  = (fill != '0);
  assign bus.AHasSpace = (free != '0);
  assign bus.AFreeSize = 16'(free);
  assign bus.AWrDrop   = wrDropQ;
  assign AScanO        = wrDropQ;

endmodule

// File: tb/tb_spi_send_fifo.sv
// Self-checking bench: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations and a random phase.
module tb_spi_send_fifo;

  localparam int unsigned CAddrLen = 5;
  localparam int unsigned Depth    = 32;

  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic en    = 1'b1;
  logic sRstn = 1'b1;
  logic scanI = 1'b0;
  logic scanE = 1'b0;
  logic scanO;

  spi_send_fifo_if bus ();

  spi_send_fifo #(
    .CAddrLen (CAddrLen)
  ) dut (
    .AClkH    (clk),
    .AResetHN (rstn),
    .AClkHEn  (en),
    .AScanI   (scanI),
    .AScanO   (scanO),
    .AScanE   (scanE),
    .AResetSN (sRstn),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  byte unsigned mq[$];
  logic         mDrop = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int nBytes(input logic [3:0] s);
    if (s[3]) return 8;
    if (s[2]) return 4;
    if (s[1]) return 2;
    if (s[0]) return 1;
    return 0;
  endfunction

  // Reference model: the FIFO as a byte queue.
  always @(posedge clk) begin : model
    int  n;
    int  freeB;
    bit  ok;
    if (!rstn) begin
      mq.delete();
      mDrop = 1'b0;
    end else if (en) begin
      if (!sRstn) begin
        mq.delete();
        mDrop = 1'b0;
      end else begin
        n     = nBytes(bus.AWrSize);
        freeB = Depth - mq.size();
        ok    = (n != 0) && (n <= freeB);
        if (bus.ARdEn && mq.size() > 0) void'(mq.pop_front());
        if (ok) for (int k = 0; k < n; k++) mq.push_back(bus.ADataI[8*k +: 8]);
        mDrop = (n != 0) && !ok;
      end
    end
  end

  always @(negedge clk) begin : compare
    check("AHasData", 64'(bus.AHasData), 64'(mq.size() != 0));
    check("AHasSpace", 64'(bus.AHasSpace), 64'(mq.size() != Depth));
    check("AFreeSize", 64'(bus.AFreeSize), 64'(Depth - mq.size()));
    check("AWrDrop", 64'(bus.AWrDrop), 64'(mDrop));
    if (mq.size() != 0) check("ADataO", 64'(bus.ADataO), 64'(mq[0]));
  end

  task automatic cyc(input logic [3:0] sz, input logic [63:0] d, input logic rd);
    bus.AWrSize = sz;
    bus.ADataI  = d;
    bus.ARdEn   = rd;
    @(posedge clk);
    @(negedge clk);
    bus.AWrSize = 4'd0;
    bus.ARdEn   = 1'b0;
  endtask

  task automatic doReset();
    #1 rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn  = 1'b1;
    en    = 1'b1;
    sRstn = 1'b1;
  endtask

  task automatic fillN(input int n);
    for (int i = 0; i < n; i++) cyc(4'b0001, {$urandom, $urandom}, 1'b0);
  endtask

  task automatic popN(input int n);
    for (int i = 0; i < n; i++) cyc(4'b0000, 64'd0, 1'b1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [3:0] sz;
    int         r;
    bus.AWrSize = 4'd0;
    bus.ADataI  = 64'd0;
    bus.ARdEn   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_hasData", 64'(bus.AHasData), 64'd0);
    check("rst_hasSpace", 64'(bus.AHasSpace), 64'd1);
    check("rst_freeSize", 64'(bus.AFreeSize), 64'd32);
    check("rst_wrDrop", 64'(bus.AWrDrop), 64'd0);
    rstn = 1'b1;

    // Single Q write then drain.
    cyc(4'b1000, 64'h0807060504030201, 1'b0);
    check("q_free", 64'(bus.AFreeSize), 64'd24);
    check("q_hasData", 64'(bus.AHasData), 64'd1);
    for (int i = 0; i < 8; i++) begin
      check("q_pop", 64'(bus.ADataO), 64'(i + 1));
      cyc(4'b0000, 64'd0, 1'b1);
    end
    check("q_empty", 64'(bus.AHasData), 64'd0);

    // Exact fill, then overflow.
    doReset();
    fillN(28);
    cyc(4'b0100, {$urandom, $urandom}, 1'b0);
    check("full_free", 64'(bus.AFreeSize), 64'd0);
    check("full_space", 64'(bus.AHasSpace), 64'd0);
    cyc(4'b0001, 64'hAA, 1'b0);
    check("ovf_drop", 64'(bus.AWrDrop), 64'd1);
    check("ovf_free", 64'(bus.AFreeSize), 64'd0);
    cyc(4'b0000, 64'd0, 1'b0);
    check("ovf_dropEnd", 64'(bus.AWrDrop), 64'd0);

    // Write with simultaneous read; then a rejected write with read.
    doReset();
    fillN(24);
    cyc(4'b1000, {$urandom, $urandom}, 1'b1);
    check("wr_rd_free", 64'(bus.AFreeSize), 64'd1);
    cyc(4'b0010, {$urandom, $urandom}, 1'b1);
    check("rej_drop", 64'(bus.AWrDrop), 64'd1);
    check("rej_free", 64'(bus.AFreeSize), 64'd2);

    // Write wrapping across the array end.
    doReset();
    fillN(29);
    popN(29);
    cyc(4'b1000, 64'h1122334455667788, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("wrap_pop", 64'(bus.ADataO), 64'(8'h88 - 8'h11 * i));
      cyc(4'b0000, 64'd0, 1'b1);
    end

    // Flush beats a same-cycle write; clock enable low freezes everything.
    doReset();
    fillN(10);
    sRstn = 1'b0;
    cyc(4'b1000, {$urandom, $urandom}, 1'b1);
    sRstn = 1'b1;
    check("flush_free", 64'(bus.AFreeSize), 64'd32);
    check("flush_hasData", 64'(bus.AHasData), 64'd0);
    fillN(3);
    en = 1'b0;
    cyc(4'b1000, {$urandom, $urandom}, 1'b1);
    cyc(4'b0001, {$urandom, $urandom}, 1'b0);
    check("cen_free", 64'(bus.AFreeSize), 64'd29);
    en = 1'b1;

    // Reset in the middle of operation drops pending data.
    fillN(5);
    doReset();
    check("midrst_hasData", 64'(bus.AHasData), 64'd0);

    // Random phase.
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       sz = 4'(1 << r);
      else if (r == 4) sz = 4'($urandom_range(0, 15));
      else             sz = 4'd0;
      en    = ($urandom_range(0, 7) != 0);
      sRstn = ($urandom_range(0, 63) != 0);
      cyc(sz, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end
    en    = 1'b1;
    sRstn = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
